// File: rtl/vending_pkg.sv
// Shared definitions for the vending payout path: coin denominations and
// the change dispenser FSM encoding.
package vending_pkg;

    localparam int NUM_DENOM = 6;

    // Largest denomination first; the dispenser scans this table in index order.
    localparam logic [15:0] DENOM [NUM_DENOM] = '{16'd500, 16'd100, 16'd25, 16'd10, 16'd5, 16'd1};

    // Scan index one past the last denomination marks the end of a payout.
    localparam logic [2:0] IDX_END = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ISSUE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Out-of-table indices map to zero cents so they can never be paid.
    function automatic logic [15:0] denom_of(input logic [2:0] idx);
        logic [15:0] cents;
        case (idx)
            3'd0:    cents = DENOM[0];
            3'd1:    cents = DENOM[1];
            3'd2:    cents = DENOM[2];
            3'd3:    cents = DENOM[3];
            3'd4:    cents = DENOM[4];
            3'd5:    cents = DENOM[5];
            default: cents = 16'd0;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin request handshake between the change dispenser and the coin ejector.
interface change_dispenser_if;

    logic       O_COIN_VALID;
    logic [2:0] O_COIN_SEL;
    logic       I_COIN_READY;

    modport master (
        output O_COIN_VALID,
        output O_COIN_SEL,
        input  I_COIN_READY
    );

    modport slave (
        input  O_COIN_VALID,
        input  O_COIN_SEL,
        output I_COIN_READY
    );

endinterface

// File: rtl/coin_inventory.sv
// Per-denomination coin counters with refill (overwrite) and single-coin
// decrement ports, plus a combinational count read.
module coin_inventory
    import vending_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int INIT_CNT = 20
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             load_en,
    input  logic [2:0]       load_sel,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             dec_en,
    input  logic [2:0]       dec_sel,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r [NUM_DENOM];

    // Counter update: reset, then refill, then decrement; a zero count never wraps.
    always_ff @(posedge I_CLK) begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (I_RESET) begin
                cnt_r[i] <= INIT_VAL;
            end else if (load_en && (load_sel == 3'(i))) begin
                cnt_r[i] <= load_cnt;
            end else if (dec_en && (dec_sel == 3'(i)) && (cnt_r[i] != '0)) begin
                cnt_r[i] <= cnt_r[i] - ONE_VAL;
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Count read; the end-of-scan index reads as empty.
    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            rd_cnt = (rd_sel == 3'(i)) ? cnt_r[i] : rd_cnt;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out as coins, largest denomination first, one coin per
// ejector handshake, and reports completion and any inventory shortfall.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int INIT_CNT = 20
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_START,
    input  logic [15:0]        I_AMOUNT,
    input  logic               I_LOAD,
    input  logic [2:0]         I_LOAD_SEL,
    input  logic [CNT_W-1:0]   I_LOAD_CNT,
    change_dispenser_if.master coin,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic               O_SHORT,
    output logic [15:0]        O_REMAIN
);

    state_t           state_r, state_s;
    logic [15:0]      remain_r, remain_s;
    logic [2:0]       idx_r, idx_s;
    logic             valid_r, valid_s;
    logic [2:0]       sel_r, sel_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             short_r, short_s;
    logic [15:0]      out_rem_r, out_rem_s;
    logic             load_en_s;
    logic             dec_en_s;
    logic [15:0]      denom_s;
    logic [CNT_W-1:0] inv_cnt_s;

    coin_inventory #(
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_inv (
        .I_CLK    (I_CLK),
        .I_RESET  (I_RESET),
        .load_en  (load_en_s),
        .load_sel (I_LOAD_SEL),
        .load_cnt (I_LOAD_CNT),
        .dec_en   (dec_en_s),
        .dec_sel  (idx_r),
        .rd_sel   (idx_r),
        .rd_cnt   (inv_cnt_s)
    );

    assign denom_s = denom_of(idx_r);

    // Next-state and next-output logic for the payout FSM.
    always_comb begin
        state_s   = state_r;
        remain_s  = remain_r;
        idx_s     = idx_r;
        valid_s   = valid_r;
        sel_s     = sel_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        short_s   = short_r;
        out_rem_s = out_rem_r;
        load_en_s = 1'b0;
        dec_en_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                // A refill in the start cycle lands before the first selection.
                load_en_s = I_LOAD && (I_LOAD_SEL < 3'(NUM_DENOM));
                if (I_START) begin
                    remain_s = I_AMOUNT;
                    idx_s    = 3'd0;
                    short_s  = 1'b0;
                    busy_s   = 1'b1;
                    state_s  = S_SELECT;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_SELECT: begin
                if ((idx_r >= IDX_END) || (remain_r == 16'd0)) begin
                    state_s = S_DONE;
                end else if ((remain_r >= denom_s) && (inv_cnt_s != '0)) begin
                    valid_s = 1'b1;
                    sel_s   = idx_r;
                    state_s = S_ISSUE;
                end else begin
                    idx_s   = idx_r + 3'd1;
                    state_s = S_SELECT;
                end
            end
            S_ISSUE: begin
                // Stay on the same denomination after a coin so it can repeat.
                if (coin.I_COIN_READY) begin
                    remain_s = remain_r - denom_s;
                    dec_en_s = 1'b1;
                    valid_s  = 1'b0;
                    state_s  = S_SELECT;
                end else begin
                    valid_s  = 1'b1;
                    state_s  = S_ISSUE;
                end
            end
            S_DONE: begin
                done_s    = 1'b1;
                busy_s    = 1'b0;
                out_rem_s = remain_r;
                short_s   = (remain_r != 16'd0);
                state_s   = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_r   <= S_IDLE;
            remain_r  <= 16'd0;
            idx_r     <= 3'd0;
            valid_r   <= 1'b0;
            sel_r     <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            short_r   <= 1'b0;
            out_rem_r <= 16'd0;
        end else begin
            state_r   <= state_s;
            remain_r  <= remain_s;
            idx_r     <= idx_s;
            valid_r   <= valid_s;
            sel_r     <= sel_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            short_r   <= short_s;
            out_rem_r <= out_rem_s;
        end
    end

    assign coin.O_COIN_VALID = valid_r;
    assign coin.O_COIN_SEL   = sel_r;
    assign O_BUSY            = busy_r;
    assign O_DONE            = done_r;
    assign O_SHORT           = short_r;
    assign O_REMAIN          = out_rem_r;

endmodule
